// File: rtl/axi_wr_dispatch.sv
// axi_wr_dispatch
//   Write-side sequencer of the AXI slave. It latches one axi_wr_vld beat
//   and routes it by region to the FIFO, IRAM or WRAM target. It waits for
//   that target's ack, then returns a one-cycle *_wr_done pulse. Only one
//   beat is in flight at a time. A beat that arrives while busy is dropped
//   and flagged in the sticky disp_ovr bit. An invalid region completes on
//   the FIFO done path with fifo_err set (SLVERR).
//
//   Optional feature macro: AXI_WR_DISPATCH_TMO_EN
//     When defined, an ack timeout of TMO_CYC cycles is built in. On timeout
//     the request is dropped and the beat completes as fifo_wr_done+fifo_err.
//     When undefined, ISSUE waits for the ack indefinitely.
//
// Ports
//   clk, rst_n             clock; synchronous reset, active-high despite the name
//   axi_wr_vld/addr/data/strb/region   beat from the AXI write interface
//   fifo/iram/wram_wr_done one-cycle completion pulses; fifo_err marks an error
//   tgt_addr/data/mask     held beat, shared by all targets
//   fifo/iram/wram_req/ack per-target handshake; fifo_full holds back fifo_req
//   disp_busy              state != IDLE
//   disp_ovr               sticky "beat arrived while busy"
module axi_wr_dispatch #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 64,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              axi_wr_vld,
  input  logic [ADDR_W-1:0] axi_wr_addr,
  input  logic [DATA_W-1:0] axi_wr_data,
  input  logic [DATA_W-1:0] axi_wr_strb,
  input  logic [1:0]        axi_wr_region,
  output logic              fifo_wr_done,
  output logic              fifo_err,
  output logic              iram_wr_done,
  output logic              wram_wr_done,
  output logic [ADDR_W-1:0] tgt_addr,
  output logic [DATA_W-1:0] tgt_data,
  output logic [DATA_W-1:0] tgt_mask,
  output logic              fifo_req,
  input  logic              fifo_ack,
  output logic              iram_req,
  input  logic              iram_ack,
  output logic              wram_req,
  input  logic              wram_ack,
  input  logic              fifo_full,
  output logic              disp_busy,
  output logic              disp_ovr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] RGN_INVALID = 2'b11;

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] mask_reg;
  logic [1:0]        region_reg;
  logic [2:0]        done_reg;   // {wram, iram, fifo}
  logic              err_reg;
  logic              ovr_reg;

  logic [2:0] req_vec;
  logic [2:0] ack_vec;
  logic       ack_hit;

  if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_cyc_out_of_range
    $error("axi_wr_dispatch: TMO_CYC must be in 1..255");
  end

  // Requests are combinational from the held region, so the target sees the
  // request in the first ISSUE cycle. The FIFO request is additionally held
  // back while the FIFO reports full.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_req
    if (gi == 0) begin : g_fifo
      assign req_vec[gi] = (state_reg == ISSUE) && (region_reg == 2'(gi)) && !fifo_full;
    end else begin : g_ram
      assign req_vec[gi] = (state_reg == ISSUE) && (region_reg == 2'(gi));
    end
  end

  assign ack_vec = {wram_ack, iram_ack, fifo_ack};
  // Only an ack from the target whose request is high this cycle counts.
  assign ack_hit = |(req_vec & ack_vec);

`ifdef AXI_WR_DISPATCH_TMO_EN
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  logic [7:0] tmo_cnt_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      mask_reg    <= '0;
      region_reg  <= '0;
      done_reg    <= '0;
      err_reg     <= 1'b0;
      ovr_reg     <= 1'b0;
`ifdef AXI_WR_DISPATCH_TMO_EN
      tmo_cnt_reg <= '0;
`endif
    end else begin
      // Done outputs are pulses: they are set only on the edge into DONE.
      done_reg <= '0;
      err_reg  <= 1'b0;

      if (axi_wr_vld && (state_reg != IDLE)) begin
        ovr_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (axi_wr_vld) begin
            addr_reg   <= axi_wr_addr;
            data_reg   <= axi_wr_data;
            mask_reg   <= axi_wr_strb;
            region_reg <= axi_wr_region;
            if (axi_wr_region == RGN_INVALID) begin
              state_reg <= DONE;
              done_reg  <= 3'b001;
              err_reg   <= 1'b1;
            end else begin
              state_reg <= ISSUE;
`ifdef AXI_WR_DISPATCH_TMO_EN
              tmo_cnt_reg <= '0;
`endif
            end
          end
        end

        ISSUE: begin
          if (ack_hit) begin
            state_reg <= DONE;
            done_reg  <= 3'b001 << region_reg;
          end
`ifdef AXI_WR_DISPATCH_TMO_EN
          // The last waiting cycle sees the counter at TMO_CYC-1. Cycles
          // stalled on fifo_full count as waiting too.
          else if (tmo_cnt_reg == TMO_LAST) begin
            state_reg <= DONE;
            done_reg  <= 3'b001;
            err_reg   <= 1'b1;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
`endif
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_done = done_reg[0];
  assign iram_wr_done = done_reg[1];
  assign wram_wr_done = done_reg[2];
  assign fifo_err     = err_reg;
  assign fifo_req     = req_vec[0];
  assign iram_req     = req_vec[1];
  assign wram_req     = req_vec[2];
  assign tgt_addr     = addr_reg;
  assign tgt_data     = data_reg;
  assign tgt_mask     = mask_reg;
  assign disp_busy    = (state_reg != IDLE);
  assign disp_ovr     = ovr_reg;

endmodule

// File: tb/tb_axi_wr_dispatch.sv
// Self-checking bench for axi_wr_dispatch (default build, no timeout).
// For each beat, a reference model derives the expected per-cycle behaviour
// from the beat's timing parameters:
//   - cycle 0: vld is driven.
//   - cycles 1..full: FIFO stall, region 00 only.
//   - the following cycles: the selected request is high until its ack arrives.
//   - the cycle after the ack: the done pulse.
// An invalid region has its done pulse at cycle 1 and never raises a request.
module tb_axi_wr_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        axi_wr_vld;
  logic [10:0] axi_wr_addr;
  logic [63:0] axi_wr_data;
  logic [63:0] axi_wr_strb;
  logic [1:0]  axi_wr_region;
  logic        fifo_wr_done, fifo_err, iram_wr_done, wram_wr_done;
  logic [10:0] tgt_addr;
  logic [63:0] tgt_data, tgt_mask;
  logic        fifo_req, iram_req, wram_req;
  logic        fifo_ack, iram_ack, wram_ack;
  logic        fifo_full;
  logic        disp_busy, disp_ovr;

  int n_chk  = 0;
  int n_pass = 0;
  int n_beat = 0;
  logic exp_ovr = 1'b0;

  always #5 clk = ~clk;

  axi_wr_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .axi_wr_vld(axi_wr_vld), .axi_wr_addr(axi_wr_addr), .axi_wr_data(axi_wr_data),
    .axi_wr_strb(axi_wr_strb), .axi_wr_region(axi_wr_region),
    .fifo_wr_done(fifo_wr_done), .fifo_err(fifo_err),
    .iram_wr_done(iram_wr_done), .wram_wr_done(wram_wr_done),
    .tgt_addr(tgt_addr), .tgt_data(tgt_data), .tgt_mask(tgt_mask),
    .fifo_req(fifo_req), .fifo_ack(fifo_ack),
    .iram_req(iram_req), .iram_ack(iram_ack),
    .wram_req(wram_req), .wram_ack(wram_ack),
    .fifo_full(fifo_full), .disp_busy(disp_busy), .disp_ovr(disp_ovr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive inputs shortly after the rising edge; sample 1 ns later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    axi_wr_vld    = 1'b0;
    axi_wr_addr   = '0;
    axi_wr_data   = '0;
    axi_wr_strb   = '0;
    axi_wr_region = '0;
    fifo_ack      = 1'b0;
    iram_ack      = 1'b0;
    wram_ack      = 1'b0;
    fifo_full     = 1'b0;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_req"},  {61'd0, wram_req, iram_req, fifo_req}, 64'd0);
    chk({tag, "_done"}, {60'd0, fifo_err, wram_wr_done, iram_wr_done, fifo_wr_done}, 64'd0);
    chk({tag, "_busy"}, {63'd0, disp_busy}, 64'd0);
  endtask

  // One complete beat. ovr_at is the cycle that carries an extra vld while
  // busy; -1 means there is no extra vld.
  task automatic beat(input logic [1:0] rg, input logic [10:0] ad, input logic [63:0] dt,
                      input logic [63:0] sb, input int full_cyc, input int ack_dly,
                      input int ovr_at);
    int         req_lo, req_hi, done_cyc;
    logic [2:0] sel;
    logic       exp_err;
    logic [2:0] exp_req, exp_done, stray, got_req, got_done;
    if (rg == 2'b11) begin
      req_lo = 1; req_hi = 0; done_cyc = 1; sel = 3'b001; exp_err = 1'b1;
    end else begin
      req_lo   = 1 + ((rg == 2'b00) ? full_cyc : 0);
      req_hi   = req_lo + ack_dly;
      done_cyc = req_hi + 1;
      sel      = 3'b001 << rg;
      exp_err  = 1'b0;
    end
    for (int c = 0; c <= done_cyc; c++) begin
      next_cycle();
      axi_wr_vld = (c == 0) || (c == ovr_at);
      if (c == 0) begin
        axi_wr_addr = ad; axi_wr_data = dt; axi_wr_strb = sb; axi_wr_region = rg;
      end else begin
        // Once the beat is held, the AXI-side fields must have no effect.
        axi_wr_addr   = 11'($urandom);
        axi_wr_data   = {$urandom, $urandom};
        axi_wr_strb   = {$urandom, $urandom};
        axi_wr_region = 2'($urandom);
      end
      fifo_full = (c >= 1) && (c <= full_cyc);
      // The non-selected acks get random noise. The selected ack is held low
      // while its request is waiting and rises exactly at req_hi.
      stray = 3'($urandom);
      for (int t = 0; t < 3; t++) begin
        if (sel[t] && rg != 2'b11 && c >= req_lo && c <= req_hi)
          stray[t] = (c == req_hi);
      end
      {wram_ack, iram_ack, fifo_ack} = stray;
      #1;
      exp_req  = (c >= req_lo && c <= req_hi) ? sel : 3'b000;
      exp_done = (c == done_cyc) ? sel : 3'b000;
      got_req  = {wram_req, iram_req, fifo_req};
      got_done = {wram_wr_done, iram_wr_done, fifo_wr_done};
      chk($sformatf("b%0d_c%0d_req", n_beat, c),  {61'd0, got_req},  {61'd0, exp_req});
      chk($sformatf("b%0d_c%0d_done", n_beat, c), {61'd0, got_done}, {61'd0, exp_done});
      chk($sformatf("b%0d_c%0d_err", n_beat, c),  {63'd0, fifo_err},
          {63'd0, (c == done_cyc) && exp_err});
      chk($sformatf("b%0d_c%0d_busy", n_beat, c), {63'd0, disp_busy}, {63'd0, c != 0});
      chk($sformatf("b%0d_c%0d_ovr", n_beat, c),  {63'd0, disp_ovr}, {63'd0, exp_ovr});
      if (c >= 1) begin
        chk($sformatf("b%0d_c%0d_addr", n_beat, c), {53'd0, tgt_addr}, {53'd0, ad});
        chk($sformatf("b%0d_c%0d_data", n_beat, c), tgt_data, dt);
        chk($sformatf("b%0d_c%0d_mask", n_beat, c), tgt_mask, sb);
      end
      if (c != 0 && c == ovr_at) exp_ovr = 1'b1;
    end
    $display("beat %0d: region=%0d addr=%h data=%h full=%0d ack_dly=%0d ovr_at=%0d done_cycle=%0d",
             n_beat, rg, ad, dt, full_cyc, ack_dly, ovr_at, done_cyc);
    n_beat++;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    repeat (3) next_cycle();
    rst_n = 1'b0;
    #1;
    chk_all_quiet("reset");
    chk("reset_ovr",  {63'd0, disp_ovr}, 64'd0);
    chk("reset_data", tgt_data, 64'd0);
    chk("reset_addr", {53'd0, tgt_addr}, 64'd0);

    // IRAM: the ack arrives in the first request cycle.
    beat(2'b01, 11'h010, 64'hA5A5_A5A5_A5A5_A5A5, 64'hFFFF_0000_FFFF_0000, 0, 0, -1);
    // FIFO stalled by fifo_full for 5 cycles, then acked at once.
    beat(2'b00, 11'h123, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 5, 0, -1);
    // Invalid region: error completion one cycle after vld, no request.
    beat(2'b11, 11'h7FF, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 0, -1);
    // WRAM with a late ack and a second vld while waiting (overrun).
    beat(2'b10, 11'h055, 64'h1111_2222_3333_4444, 64'h00FF_00FF_00FF_00FF, 0, 3, 2);

    // Reset while the WRAM request is high.
    next_cycle();
    axi_wr_vld = 1'b1; axi_wr_region = 2'b10; axi_wr_addr = 11'h321;
    axi_wr_data = 64'hCAFE_F00D_CAFE_F00D; axi_wr_strb = '1;
    next_cycle();
    idle_inputs();
    #1;
    chk("mid_wram_req", {63'd0, wram_req}, 64'd1);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    rst_n = 1'b0;
    wram_ack = 1'b1;  // no request is pending, so this ack is ignored
    #1;
    exp_ovr = 1'b0;
    chk_all_quiet("post_rst");
    chk("post_rst_ovr",  {63'd0, disp_ovr}, 64'd0);
    chk("post_rst_data", tgt_data, 64'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      wram_ack = 1'b0;
      #1;
      chk($sformatf("post_rst_quiet%0d", i), {60'd0, fifo_err, wram_wr_done, iram_wr_done, fifo_wr_done}, 64'd0);
    end
    $display("reset during WRAM issue: aborted beat produced no done pulse");
    beat(2'b10, 11'h00A, 64'h5A5A_5A5A_5A5A_5A5A, 64'hF0F0_F0F0_F0F0_F0F0, 0, 0, -1);

    // Randomized beats, including back-to-back starts and idle gaps.
    for (int k = 0; k < 24; k++) begin
      logic [1:0] rg;
      int full_cyc, ack_dly, ovr_at, gap;
      rg       = 2'($urandom);
      full_cyc = $urandom_range(0, 3);
      ack_dly  = $urandom_range(0, 3);
      ovr_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : -1;
      gap      = $urandom_range(0, 2);
      beat(rg, 11'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, full_cyc, ack_dly, ovr_at);
      for (int g = 0; g < gap; g++) next_cycle();
    end

    next_cycle();
    #1;
    chk_all_quiet("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
